grf_multiport: RTL
==================

# grf_multiport

Parametrised general register file for the pipelined MIPS core: two combinational read ports with write-through bypass, two prioritised write ports, a per-register pending scoreboard for hazard detection, and a sequential clear engine that zeroes the array one entry per cycle without a global reset. Sits between decode (reads, scoreboard set) and writeback (port A: main pipe, port B: multi-cycle unit).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 is hardwired zero (writes and scoreboard sets to it are discarded)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- rd_addr1, rd_addr2  input  ADDR_W  read addresses
- rd_data1, rd_data2  output  DATA_W  read data (combinational)
- rd_pend1, rd_pend2  output  1  pending flag of addressed entry (combinational)
- we_a, wa_addr, wa_data  input  1/ADDR_W/DATA_W  write port A (higher priority)
- we_b, wb_addr, wb_data  input  1/ADDR_W/DATA_W  write port B
- sb_set, sb_set_addr  input  1/ADDR_W  mark entry pending (producer issued)
- clr_req  input  1  start sequential clear (single-cycle pulse)
- clr_busy  output  1  clear engine running
- clr_done  output  1  one-cycle pulse when clear finishes

## Operation
- Reset (async, immediate): all entries 0, all pending bits 0, FSM IDLE, sweep counter 0, clr_busy 0, clr_done 0.
- A write is effective when its enable is high, FSM is IDLE, and (ZERO_REG=0 or address != 0).
- Writes: effective A and B to different entries both commit at the edge; same entry -> A data commits, B dropped.
- Bypass: rd_dataN = wa_data if A effective and wa_addr == rd_addrN; else wb_data if B effective and wb_addr == rd_addrN; else stored value. Entry 0 with ZERO_REG=1 always reads 0.
- Scoreboard: effective write to entry clears its pending bit at the edge; sb_set (IDLE only, not entry 0 when ZERO_REG=1) sets it. Set and write to the same entry in one cycle -> bit ends set (new producer wins).
- rd_pendN = stored pending bit AND NOT (effective write to rd_addrN this cycle); sb_set in the same cycle is not reflected until next cycle.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req = 1; counter loads 0.
  - CLEAR: each edge writes 0 to entry[counter], clears pending[counter], counter increments (ADDR_W bits, wraps to 0 after DEPTH-1).
  - CLEAR -> IDLE on the edge that clears entry DEPTH-1; clr_done = 1 for the following cycle.
- In CLEAR: write ports, sb_set, and clr_req are ignored (dropped, not queued); reads return stored contents with no bypass; rd_pend reflects stored bits.
- clr_req while clr_busy = 1: ignored, no restart.
- Reset asserted mid-clear: immediate return to reset state, no clr_done pulse.

## Timing
- Read and rd_pend: zero latency (combinational from addresses, write ports, stored state).
- Write to read visibility: same cycle via bypass, from stored array the cycle after the edge.
- clr_req sampled high at edge E0 -> clr_busy = 1 from E0 until E(DEPTH); entry k zeroed at edge E(k+1); clr_busy = 0 and clr_done = 1 during the cycle after E(DEPTH); clr_done = 0 after E(DEPTH+1).
- Total clear latency: DEPTH cycles busy; writes accepted again in the cycle clr_done is high.
- clr_busy and clr_done are registered outputs.

## Test plan
- Reset then read all 32 entries -> all rd_data 0, rd_pend 0, clr_busy 0; write 0xDEADBEEF to entry 0 -> still reads 0.
- we_a=1 wa_addr=5 wa_data=0x11111111, we_b=1 wb_addr=5 wb_data=0x22222222, rd_addr1=5 -> same cycle rd_data1=0x11111111; next cycle stored value 0x11111111.
- sb_set entry 9 -> next cycle rd_pend1(9)=1; port B writes 0x5 to 9 -> rd_pend1=0 same cycle, rd_data1=0x5; sb_set and we_a to entry 9 together -> pend=1 next cycle.
- Fill entries 1..31 with index value, pulse clr_req -> clr_busy high 32 cycles; after edge E3 entries 0..2 read 0, entry 3 still 3; port A write during busy dropped; clr_done pulses once; all entries 0 after.
- Second clr_req mid-clear at cycle 10 -> no restart, clr_done exactly 32 cycles after first request's edge.
- Assert reset at sweep cycle 7 (async, between edges) -> clr_busy falls immediately, all outputs reset values, no clr_done.

Source files
------------

// File: rtl/grf_multiport.sv
// grf_multiport: general register file with two bypassed read ports, two
// prioritised write ports, a pending-bit scoreboard and a sequential clear
// engine that zeroes one entry per cycle.
module grf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic ZERO_EN = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic idle_s;
  logic a_eff_s;
  logic b_eff_s;
  logic sb_eff_s;

  // An address may be modified unless it is the hardwired zero entry.
  function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
    return (!ZERO_EN) || (addr != ADDR_ZERO);
  endfunction

  // Qualify write ports and scoreboard set: only honoured while idle.
  always_comb begin
    idle_s   = (state_q == ST_IDLE);
    a_eff_s  = we_a   && idle_s && addr_writable(wa_addr);
    b_eff_s  = we_b   && idle_s && addr_writable(wb_addr);
    sb_eff_s = sb_set && idle_s && addr_writable(sb_set_addr);
  end

  // Clear-engine next state, sweep counter and registered status outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d    = ST_CLEAR;
          cnt_d      = ADDR_ZERO;
          clr_busy_d = 1'b1;
        end else begin
          clr_busy_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_LAST) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ADDR_ZERO;
      end
    endcase
  end

  // Per-entry next value: sweep clear, then port A over port B, else hold.
  // Pending: sweep clear, then new producer set beats a completing write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!idle_s && (cnt_q == ADDR_W'(i))) begin
        mem_d[i] = {DATA_W{1'b0}};
      end else if (a_eff_s && (wa_addr == ADDR_W'(i))) begin
        mem_d[i] = wa_data;
      end else if (b_eff_s && (wb_addr == ADDR_W'(i))) begin
        mem_d[i] = wb_data;
      end else begin
        mem_d[i] = mem_q[i];
      end

      if (!idle_s && (cnt_q == ADDR_W'(i))) begin
        pend_d[i] = 1'b0;
      end else if (sb_eff_s && (sb_set_addr == ADDR_W'(i))) begin
        pend_d[i] = 1'b1;
      end else if ((a_eff_s && (wa_addr == ADDR_W'(i))) ||
                   (b_eff_s && (wb_addr == ADDR_W'(i)))) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Read port 1: zero entry, then A bypass, then B bypass, then storage.
  always_comb begin
    if (ZERO_EN && (rd_addr1 == ADDR_ZERO)) begin
      rd_data1 = {DATA_W{1'b0}};
    end else if (a_eff_s && (wa_addr == rd_addr1)) begin
      rd_data1 = wa_data;
    end else if (b_eff_s && (wb_addr == rd_addr1)) begin
      rd_data1 = wb_data;
    end else begin
      rd_data1 = mem_q[rd_addr1];
    end
    rd_pend1 = pend_q[rd_addr1] &
               ~((a_eff_s && (wa_addr == rd_addr1)) ||
                 (b_eff_s && (wb_addr == rd_addr1)));
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    if (ZERO_EN && (rd_addr2 == ADDR_ZERO)) begin
      rd_data2 = {DATA_W{1'b0}};
    end else if (a_eff_s && (wa_addr == rd_addr2)) begin
      rd_data2 = wa_data;
    end else if (b_eff_s && (wb_addr == rd_addr2)) begin
      rd_data2 = wb_data;
    end else begin
      rd_data2 = mem_q[rd_addr2];
    end
    rd_pend2 = pend_q[rd_addr2] &
               ~((a_eff_s && (wa_addr == rd_addr2)) ||
                 (b_eff_s && (wb_addr == rd_addr2)));
  end

  // State, counter, array and scoreboard registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= ADDR_ZERO;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      pend_q     <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      pend_q     <= pend_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule
